// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit bridge.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_LOW, WAIT_HIGH} tx_state_t;

  localparam int UART_TX_DEFAULT_DEPTH   = 8;
  localparam int UART_TX_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_bridge_byte_fifo.sv
// Circular byte FIFO with registered full/empty/count flags.
module byte_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = UART_TX_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;

  // Gate on the registered flags so a same-edge pop never frees room for a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// CPU-to-UART transmit bridge: byte FIFO drained by a txclk/txready handshake FSM.
module uart_tx_bridge
  import uart_tx_pkg::*;
#(
  parameter int DEPTH        = UART_TX_DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = UART_TX_DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic [7:0]               txdata,
  output logic                     txclk,
  input  logic                     txready
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_next;
  logic [7:0]    head;
  logic          load;
  logic          pop;

  // The head byte leaves the FIFO on the edge that ends the strobe cycle.
  assign pop  = (state == STROBE);
  assign busy = (state != IDLE);

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && txready) begin
          state_next = LOAD;
          load       = 1'b1;
        end
      end
      LOAD: begin
        state_next = STROBE;
      end
      STROBE: begin
        tcnt_next  = '0;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A UART that never drops txready is assumed to have taken the byte.
        if (!txready) begin
          state_next = WAIT_HIGH;
        end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end
      WAIT_HIGH: begin
        if (txready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      tcnt     <= '0;
      txdata   <= 8'h00;
      txclk    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (load) begin
        txdata <= head;
      end
      txclk <= (state_next == STROBE);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed self-checking bench for uart_tx_bridge (DEPTH=8, BUSY_TIMEOUT=16).
module tb_uart_tx_bridge;
  import uart_tx_pkg::*;

  logic       clk;
  logic       nrst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       busy;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready;

  int vectors;
  int miscompares;

  uart_tx_bridge #(
    .DEPTH        (8),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in the strobe cycle so the caller can act before the pop edge.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (txclk !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_txclk"}, 32'(txclk), 32'd1);
    chk({tag, "_txdata"}, 32'(txdata), 32'(exp));
  endtask

  // UART model: drop txready one cycle after the strobe, raise it five cycles later.
  task automatic uart_handshake(input string tag);
    step();
    chk({tag, "_single_pulse"}, 32'(txclk), 32'd0);
    txready = 1'b0;
    step();
    chk({tag, "_wait_high"}, 32'(dut.state), 32'(WAIT_HIGH));
    repeat (4) step();
    txready = 1'b1;
  endtask

  initial begin
    logic [7:0] t3_bytes [3];
    int strobes;
    vectors     = 0;
    miscompares = 0;
    t3_bytes    = '{8'h10, 8'h20, 8'h30};
    nrst    = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    txready = 1'b1;

    #2 nrst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txdata", 32'(txdata), 32'h00);
    chk("rst_txclk", 32'(txclk), 32'd0);
    step();
    step();
    nrst = 1'b1;
    step();

    // Single byte latency and timeout release
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    chk("t2_k_count", 32'(count), 32'd1);
    chk("t2_k_txclk", 32'(txclk), 32'd0);
    step();
    chk("t2_load_busy", 32'(busy), 32'd1);
    chk("t2_load_txclk", 32'(txclk), 32'd0);
    chk("t2_load_txdata", 32'(txdata), 32'h41);
    step();
    chk("t2_strobe_txclk", 32'(txclk), 32'd1);
    chk("t2_strobe_txdata", 32'(txdata), 32'h41);
    chk("t2_strobe_count", 32'(count), 32'd1);
    step();
    chk("t2_pop_txclk", 32'(txclk), 32'd0);
    chk("t2_pop_count", 32'(count), 32'd0);
    chk("t2_pop_empty", 32'(empty), 32'd1);
    chk("t2_pop_busy", 32'(busy), 32'd1);
    repeat (15) step();
    chk("t2_busy_before_timeout", 32'(busy), 32'd1);
    step();
    chk("t2_busy_after_timeout", 32'(busy), 32'd0);

    // Three bytes through the txready handshake
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h20;
    step();
    wr_data = 8'h30;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_byte($sformatf("t3_byte%0d", i), t3_bytes[i]);
      uart_handshake($sformatf("t3_hs%0d", i));
    end
    step();
    chk("t3_idle_busy", 32'(busy), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);

    // Fill with txready low, overflow, then drain across the pointer wrap
    txready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 7) begin
        chk("t4_full_after8", 32'(full), 32'd1);
        chk("t4_count_after8", 32'(count), 32'd8);
        chk("t4_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_busy_held", 32'(busy), 32'd0);
    txready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_byte($sformatf("t4_byte%0d", i), 8'(i));
      step();
    end
    strobes = 0;
    repeat (40) begin
      step();
      if (txclk === 1'b1) strobes++;
    end
    chk("t4_no_extra_strobes", 32'(strobes), 32'd0);
    chk("t4_drained_empty", 32'(empty), 32'd1);

    // Full FIFO: pop and dropped write on the same edge, then reset mid-strobe
    nrst = 1'b0;
    #1 nrst = 1'b1;
    step();
    txready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_overflow_clear", 32'(overflow), 32'd0);
    txready = 1'b1;
    expect_byte("t5_first", 8'h50);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("t5_count", 32'(count), 32'd7);
    chk("t5_overflow", 32'(overflow), 32'd1);
    chk("t5_not_full", 32'(full), 32'd0);
    expect_byte("t1_second", 8'h51);
    #1 nrst = 1'b0;
    #1;
    chk("t1_txclk", 32'(txclk), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    #2 nrst = 1'b1;
    step();
    chk("t1_txdata", 32'(txdata), 32'h00);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Same-edge write and pop at count 3, order kept across the wrap
    txready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    txready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_byte($sformatf("t6_byte%0d", i), 8'h60 + 8'(i));
      step();
    end
    expect_byte("t6_byte3", 8'h63);
    chk("t6_count_before", 32'(count), 32'd3);
    wr_en = 1'b1; wr_data = 8'h66;
    step();
    wr_en = 1'b0;
    chk("t6_count_same_edge", 32'(count), 32'd3);
    wr_en = 1'b1; wr_data = 8'h67;
    step();
    wr_data = 8'h68;
    step();
    wr_en = 1'b0;
    chk("t6_count_refill", 32'(count), 32'd5);
    for (int i = 4; i < 9; i++) begin
      expect_byte($sformatf("t6_byte%0d", i), 8'h60 + 8'(i));
      step();
    end
    chk("t6_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
